// File: rtl/display_pkg.sv
// Shared constants, state encoding and character codes for the display console writer.
package display_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_HT    = 7'h09;
    localparam logic [6:0] CH_SPACE = 7'h20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_ALL  = 2'd2,
        TAB      = 2'd3
    } state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c != 7'h7F);
    endfunction

endpackage

// File: rtl/display_console_ctrl_if.sv
// Character stream, buffer write port and cursor status of the display console writer.
interface display_console_ctrl_if;

    logic        char_valid;
    logic [6:0]  char_data;
    logic        char_ready;
    logic        buf_we;
    logic [11:0] buf_addr;
    logic [6:0]  buf_wdata;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    modport slave (
        input  char_valid, char_data,
        output char_ready, buf_we, buf_addr, buf_wdata, cursor_x, cursor_y, busy
    );

    modport master (
        output char_valid, char_data,
        input  char_ready, buf_we, buf_addr, buf_wdata, cursor_x, cursor_y, busy
    );

endinterface

// File: rtl/display_addr_calc.sv
// Cell address row*80+col via shift-add; max result is 2399, so 12 bits never overflow.
module display_addr_calc (
    input  logic [6:0]  x,
    input  logic [4:0]  y,
    output logic [11:0] addr
);

    assign addr = {1'b0, y, 6'b0} + {3'b0, y, 4'b0} + {5'b0, x};

endmodule

// File: rtl/display_console_ctrl.sv
// Terminal-style writer for the 80x30 display buffer: owns the cursor, sequences clears/BS.
// Define CONSOLE_TAB_EN to synthesise HT expansion (TAB state); otherwise HT is ignored.
//
//  state    | meaning
//  IDLE     | accepting characters, one per cycle
//  CLR_LINE | writing spaces across the cursor row, col counter 0..COLS-1
//  CLR_ALL  | writing spaces over the whole screen, row/col counters
//  TAB      | writing spaces from the cursor up to the next multiple of 8
module display_console_ctrl
    import display_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    display_console_ctrl_if.slave con
);

    state_t      state_q, state_nxt;
    logic [6:0]  x_q, x_nxt, col_q, col_nxt;
    logic [4:0]  y_q, y_nxt, row_q, row_nxt;
    logic [4:0]  y_adv;
    logic        we_q, we_nxt, ready_q;
    logic [11:0] addr_q;
    logic [6:0]  wdata_q, wdata_nxt;
    logic [6:0]  calc_x;
    logic [4:0]  calc_y;
    logic [11:0] calc_addr;
    logic [6:0]  ch;

    assign ch    = con.char_data;
    assign y_adv = (y_q == ROW_LAST) ? 5'd0 : y_q + 5'd1;

    display_addr_calc u_addr_calc (
        .x    (calc_x),
        .y    (calc_y),
        .addr (calc_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (con.char_valid) begin
                    if (is_printable(ch)) begin
                        if (x_q == COL_LAST) state_nxt = CLR_LINE;
                    end else if (ch == CH_LF) begin
                        state_nxt = CLR_LINE;
                    end else if (ch == CH_FF) begin
                        state_nxt = CLR_ALL;
`ifdef CONSOLE_TAB_EN
                    end else if (ch == CH_HT) begin
                        state_nxt = TAB;
`endif
                    end
                end
            end
            CLR_LINE: if (col_q == COL_LAST) state_nxt = IDLE;
            CLR_ALL:  if (col_q == COL_LAST && row_q == ROW_LAST) state_nxt = IDLE;
`ifdef CONSOLE_TAB_EN
            // Column 79 is also a tab stop boundary; the newline takes priority.
            TAB: begin
                if (x_q == COL_LAST)       state_nxt = CLR_LINE;
                else if (x_q[2:0] == 3'd7) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_nxt     = x_q;
        y_nxt     = y_q;
        col_nxt   = col_q;
        row_nxt   = row_q;
        we_nxt    = 1'b0;
        wdata_nxt = CH_SPACE;
        calc_x    = x_q;
        calc_y    = y_q;
        case (state_q)
            IDLE: begin
                if (con.char_valid) begin
                    if (is_printable(ch)) begin
                        we_nxt    = 1'b1;
                        wdata_nxt = ch;
                        if (x_q == COL_LAST) begin
                            x_nxt   = 7'd0;
                            y_nxt   = y_adv;
                            col_nxt = 7'd0;
                        end else begin
                            x_nxt = x_q + 7'd1;
                        end
                    end else if (ch == CH_LF) begin
                        x_nxt   = 7'd0;
                        y_nxt   = y_adv;
                        col_nxt = 7'd0;
                    end else if (ch == CH_CR) begin
                        x_nxt = 7'd0;
                    end else if (ch == CH_BS) begin
                        if (x_q != 7'd0) begin
                            x_nxt  = x_q - 7'd1;
                            calc_x = x_q - 7'd1;
                            we_nxt = 1'b1;
                        end
                    end else if (ch == CH_FF) begin
                        col_nxt = 7'd0;
                        row_nxt = 5'd0;
                    end
                end
            end
            CLR_LINE: begin
                we_nxt  = 1'b1;
                calc_x  = col_q;
                col_nxt = (col_q == COL_LAST) ? 7'd0 : col_q + 7'd1;
            end
            CLR_ALL: begin
                we_nxt = 1'b1;
                calc_x = col_q;
                calc_y = row_q;
                if (col_q == COL_LAST) begin
                    col_nxt = 7'd0;
                    if (row_q == ROW_LAST) begin
                        row_nxt = 5'd0;
                        x_nxt   = 7'd0;
                        y_nxt   = 5'd0;
                    end else begin
                        row_nxt = row_q + 5'd1;
                    end
                end else begin
                    col_nxt = col_q + 7'd1;
                end
            end
`ifdef CONSOLE_TAB_EN
            TAB: begin
                we_nxt = 1'b1;
                if (x_q == COL_LAST) begin
                    x_nxt   = 7'd0;
                    y_nxt   = y_adv;
                    col_nxt = 7'd0;
                end else begin
                    x_nxt = x_q + 7'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Address and data hold their last values between write pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= 7'd0;
            y_q     <= 5'd0;
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            we_q    <= 1'b0;
            addr_q  <= 12'd0;
            wdata_q <= 7'd0;
            ready_q <= ~CLEAR_ON_RESET;
        end else begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            we_q    <= we_nxt;
            ready_q <= (state_nxt == IDLE);
            if (we_nxt) begin
                addr_q  <= calc_addr;
                wdata_q <= wdata_nxt;
            end
        end
    end

    assign con.char_ready = ready_q;
    assign con.busy       = ~ready_q;
    assign con.buf_we     = we_q;
    assign con.buf_addr   = addr_q;
    assign con.buf_wdata  = wdata_q;
    assign con.cursor_x   = x_q;
    assign con.cursor_y   = y_q;

endmodule

// File: tb/tb_display_console_ctrl.sv
// Randomized bench for display_console_ctrl against a cursor/write-list model of the console rules.
module tb_display_console_ctrl;
    import display_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_console_ctrl_if con();

    display_console_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .con   (con.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mx = 0;
    int my = 0;
    int n_ff = 0;
    logic [18:0] exp_q[$];
    logic [18:0] act_q[$];
    int act_t[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset && con.buf_we) begin
            act_q.push_back({con.buf_addr, con.buf_wdata});
            act_t.push_back(cyc);
        end
    end

    function automatic void push_wr(input int a, input logic [6:0] d);
        exp_q.push_back({12'(a), d});
    endfunction

    task automatic model_newline();
        mx = 0;
        my = (my == ROWS - 1) ? 0 : my + 1;
        for (int i = 0; i < COLS; i++) push_wr(my * COLS + i, CH_SPACE);
    endtask

    task automatic model_char(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_wr(my * COLS + mx, c);
            if (mx == COLS - 1) model_newline();
            else mx++;
        end else if (c == CH_LF) begin
            model_newline();
        end else if (c == CH_CR) begin
            mx = 0;
        end else if (c == CH_BS) begin
            if (mx > 0) begin
                mx--;
                push_wr(my * COLS + mx, CH_SPACE);
            end
        end else if (c == CH_FF) begin
            for (int i = 0; i < ROWS * COLS; i++) push_wr(i, CH_SPACE);
            mx = 0;
            my = 0;
`ifdef CONSOLE_TAB_EN
        end else if (c == CH_HT) begin : ht
            bit done;
            done = 1'b0;
            while (!done) begin
                push_wr(my * COLS + mx, CH_SPACE);
                if (mx + 1 == COLS) begin
                    model_newline();
                    done = 1'b1;
                end else begin
                    mx++;
                    if (mx % 8 == 0) done = 1'b1;
                end
            end
`endif
        end
    endtask

    task automatic wait_ready(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!con.char_ready && cycles < budget) begin
            cycles++;
            @(negedge clk);
        end
        if (!con.char_ready) check({tag, "_timeout"}, 32'(con.char_ready), 32'd1);
    endtask

    task automatic send(input logic [6:0] c);
        int w;
        wait_ready("send", 3000, w);
        con.char_valid = 1'b1;
        con.char_data  = c;
        @(negedge clk);
        con.char_valid = 1'b0;
        model_char(c);
    endtask

    task automatic flush_compare(input string tag);
        int w;
        int idx;
        wait_ready({tag, "_idle"}, 3000, w);
        repeat (2) @(negedge clk);
        check({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
        if (exp_q.size() > 0 && act_q.size() > 0) begin
            idx = 0;
            while (idx < exp_q.size() - 1 && idx < act_q.size() - 1 && act_q[idx] === exp_q[idx]) idx++;
            check({tag, "_wr"}, 32'(act_q[idx]), 32'(exp_q[idx]));
        end
        check({tag, "_x"}, 32'(con.cursor_x), 32'(mx));
        check({tag, "_y"}, 32'(con.cursor_y), 32'(my));
        act_q.delete();
        exp_q.delete();
        act_t.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        con.char_valid = 1'b0;
        con.char_data  = 7'd0;
        repeat (2) @(negedge clk);
        act_q.delete();
        exp_q.delete();
        act_t.delete();
        mx = 0;
        my = 0;
        for (int i = 0; i < ROWS * COLS; i++) push_wr(i, CH_SPACE);
        reset = 1'b0;
    endtask

    function automatic logic [6:0] rand_char();
        int r;
        int k;
        r = $urandom_range(0, 99);
        if (r < 60) return 7'($urandom_range(32, 126));
        if (r < 68) return CH_LF;
        if (r < 74) return CH_CR;
        if (r < 82) return CH_BS;
        if (r < 88) return CH_HT;
        if (r < 99 || n_ff >= 3) begin
            k = $urandom_range(0, 32);
            if (k == 32) return 7'h7F;
            if (7'(k) == CH_FF) return 7'h00;
            return 7'(k);
        end
        n_ff++;
        return CH_FF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        con.char_valid = 1'b0;
        con.char_data  = 7'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_we",    32'(con.buf_we),     32'd0);
        check("rst_addr",  32'(con.buf_addr),   32'd0);
        check("rst_wdata", 32'(con.buf_wdata),  32'd0);
        check("rst_x",     32'(con.cursor_x),   32'd0);
        check("rst_y",     32'(con.cursor_y),   32'd0);
        check("rst_ready", 32'(con.char_ready), 32'd0);

        // power-on clear: 2400 cycles busy, then idle at (0,0)
        do_reset();
        wait_ready("por", 5000, n);
        check("por_busy_cycles", 32'(n), 32'(ROWS * COLS));
        check("por_busy_flag", 32'(con.busy), 32'd0);
        flush_compare("por");

        // back-to-back printables
        send(7'h41);
        send(7'h42);
        repeat (2) @(negedge clk);
        check("ab_gap", 32'((act_t.size() >= 2) ? act_t[1] - act_t[0] : -1), 32'd1);
        check("ab_x", 32'(con.cursor_x), 32'd2);
        flush_compare("ab");

        // full line from (0,5) wraps with a row clear
        send(CH_CR);
        repeat (5) send(CH_LF);
        flush_compare("to_row5");
        for (int i = 0; i < COLS; i++) send(7'($urandom_range(33, 126)));
        wait_ready("wrap", 200, n);
        check("wrap_busy_cycles", 32'(n), 32'(COLS));
        check("wrap_last_addr", 32'((act_q.size() > 79) ? act_q[79][18:7] : 12'd0), 32'd479);
        flush_compare("wrap");

        // bottom row LF wraps to row 0
        repeat (23) send(CH_LF);
        repeat (10) send(7'h2E);
        flush_compare("to_row29");
        send(CH_LF);
        flush_compare("lf_bottom");
        check("lf_bottom_y", 32'(con.cursor_y), 32'd0);

        // BS at column 0 does nothing
        repeat (3) send(CH_LF);
        flush_compare("to_row3");
        send(CH_BS);
        flush_compare("bs_col0");
        check("bs_col0_x", 32'(con.cursor_x), 32'd0);

        // HT at (3,0)
        send(CH_FF);
        flush_compare("ff");
        repeat (3) send(7'h58);
        flush_compare("to_x3");
        send(CH_HT);
        flush_compare("ht");
`ifdef CONSOLE_TAB_EN
        check("ht_x", 32'(con.cursor_x), 32'd8);
`else
        check("ht_x", 32'(con.cursor_x), 32'd3);
`endif

        // randomized traffic
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 25; i++) send(rand_char());
            flush_compare($sformatf("rnd%0d", blk));
        end

        // reset during a screen clear
        send(CH_CR);
        send(CH_LF);
        repeat (5) send(7'h5A);
        flush_compare("pre_ff");
        send(CH_FF);
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_we",    32'(con.buf_we),    32'd0);
        check("midrst_addr",  32'(con.buf_addr),  32'd0);
        check("midrst_wdata", 32'(con.buf_wdata), 32'd0);
        check("midrst_x",     32'(con.cursor_x),  32'd0);
        check("midrst_y",     32'(con.cursor_y),  32'd0);
        act_q.delete();
        exp_q.delete();
        act_t.delete();
        mx = 0;
        my = 0;
        for (int i = 0; i < ROWS * COLS; i++) push_wr(i, CH_SPACE);
        reset = 1'b0;
        wait_ready("midrst", 5000, n);
        check("midrst_busy_cycles", 32'(n), 32'(ROWS * COLS));
        flush_compare("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
